bit_packer: RTL

- Parametrised, sequential bit-field concatenator.
- Accepts variable-length fields, `in_len` bits at a time, over a valid/ready handshake.
- Concatenates the fields in arrival order into fixed `OUT_W`-bit words, emitted on a registered valid/ready output.
- An explicit flush emits a zero-padded partial word. Sits between field-producing logic (header/flag builders) and word-wide datapaths/buses.

---
 rtl/bit_packer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bit_packer.sv
// Packs variable-length fields into fixed OUT_W-bit words over valid/ready handshakes.
// Define BIT_PACKER_LSB_FIRST_EN for LSB-first ordering (default is MSB-first).
`timescale 1ns/1ps
module bit_packer #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 32,
    parameter int LEN_W = $clog2(IN_W + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_W-1:0]              in_data,
    input  logic [LEN_W-1:0]             in_len,
    input  logic                         in_flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W-1:0]             out_data,
    output logic [$clog2(OUT_W+1)-1:0]   out_bits,
    output logic                         out_last
);
    localparam int ACC_W = OUT_W + IN_W;
    localparam int N_W   = $clog2(ACC_W + 1);
    localparam int B_W   = $clog2(OUT_W + 1);
    localparam logic [LEN_W-1:0] IN_W_L  = LEN_W'(IN_W);
    localparam logic [N_W-1:0]   OUT_W_N = N_W'(OUT_W);
    localparam logic [B_W-1:0]   OUT_W_B = B_W'(OUT_W);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [N_W-1:0]   cnt;

    logic             slot_free;
    logic             accept;
    logic [LEN_W-1:0] len_c;
    logic [N_W-1:0]   n;
    logic [N_W-1:0]   rem_n;
    logic [ACC_W-1:0] field;
    logic [ACC_W-1:0] acc_cat;
    logic [ACC_W-1:0] rem_bits;
    logic [OUT_W-1:0] word_full;
    logic [OUT_W-1:0] word_part;
    logic [OUT_W-1:0] word_drain;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state == FILL) && slot_free && !rst;
    assign accept    = in_valid && in_ready;

    always_comb begin
        len_c = (in_len > IN_W_L) ? IN_W_L : in_len;
        field = ACC_W'(in_data) & ((ACC_W'(1) << len_c) - ACC_W'(1));
        n     = cnt + N_W'(len_c);
        rem_n = n - OUT_W_N;
`ifdef BIT_PACKER_LSB_FIRST_EN
        // acc holds the pending bits right-aligned, first-arrived bit at bit 0
        acc_cat    = acc | (field << cnt);
        word_full  = acc_cat[OUT_W-1:0];
        rem_bits   = acc_cat >> OUT_W;
        word_part  = acc_cat[OUT_W-1:0];
        word_drain = acc[OUT_W-1:0];
`else
        // acc holds the pending bits right-aligned, most recent field in the LSBs
        acc_cat    = (acc << len_c) | field;
        word_full  = OUT_W'(acc_cat >> rem_n);
        rem_bits   = acc_cat & ((ACC_W'(1) << rem_n) - ACC_W'(1));
        word_part  = OUT_W'(acc_cat << (OUT_W_N - n));
        word_drain = OUT_W'(acc << (OUT_W_N - cnt));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_bits  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                FILL: begin
                    if (accept) begin
                        if (n >= OUT_W_N) begin
                            out_valid <= 1'b1;
                            out_data  <= word_full;
                            out_bits  <= OUT_W_B;
                            out_last  <= in_flush && (rem_n == '0);
                            acc       <= rem_bits;
                            cnt       <= rem_n;
                            if (in_flush && (rem_n != '0))
                                state <= DRAIN;
                        end else if (in_flush && (n != '0)) begin
                            out_valid <= 1'b1;
                            out_data  <= word_part;
                            out_bits  <= B_W'(n);
                            out_last  <= 1'b1;
                            acc       <= '0;
                            cnt       <= '0;
                        end else begin
                            acc <= acc_cat;
                            cnt <= n;
                        end
                    end
                end
                DRAIN: begin
                    // straddle remainder left behind by a flush goes out as its own closing word
                    if (slot_free) begin
                        out_valid <= 1'b1;
                        out_data  <= word_drain;
                        out_bits  <= B_W'(cnt);
                        out_last  <= 1'b1;
                        acc       <= '0;
                        cnt       <= '0;
                        state     <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule
